// File: rtl/dl_frame_fifo.sv
// dl_frame_fifo: single-clock downlink command FIFO with frame-atomic commit.
// Words arriving under cmd_flag form a frame. The frame becomes readable only
// once it has been received completely. Frames that overflow the storage or
// exceed MAX_FRAME words are discarded whole and counted in frame_drop_cnt.
//
// Build option: define DL_FIFO_SHOWAHEAD_EN for first-word-fall-through reads.
// In that mode the head word sits in an output register, rdempty is that
// register's valid bit, and rdreq acknowledges the word currently shown.
module dl_frame_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int MAX_FRAME = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_flag,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              dl_fifo_rdreq,
  output logic [DATA_W-1:0] dl_fifo_rddata,
  output logic [ADDR_W:0]   dl_fifo_rdusedw,
  output logic              dl_fifo_rdempty,
  output logic              dl_fifo_wrfull,
  output logic [15:0]       frame_drop_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] MAX_LEN  = (ADDR_W+1)'(MAX_FRAME);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];

  // wr_ptr runs ahead speculatively; cm_ptr marks the end of the last
  // committed frame; rd_ptr is the next memory word to leave the buffer.
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   cm_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   occupancy;
  logic [ADDR_W:0]   mem_used;
  logic              wr_en;

  // Occupancy includes pending words so a frame in flight can never be
  // overwritten; the readable count stops at the commit pointer.
  assign occupancy      = wr_ptr - rd_ptr;
  assign mem_used       = cm_ptr - rd_ptr;
  assign dl_fifo_wrfull = (occupancy == FULL_LVL);

  // Decide whether the incoming word is stored. Fullness is judged on the
  // registered pointers only, so a pop in this cycle never frees a slot for
  // a write in the same cycle.
  always_comb begin
    wr_en = 1'b0;
    if (cmd_flag && !dl_fifo_wrfull) begin
      case (state)
        IDLE:    wr_en = 1'b1;
        RECV:    wr_en = (len < MAX_LEN);
        default: wr_en = 1'b0;
      endcase
    end
  end

  // Frame state machine: speculative write, commit on the falling run of
  // cmd_flag, or rewind to the last commit point after an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      cm_ptr         <= '0;
      len            <= '0;
      frame_drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_flag) begin
            if (wr_en) begin
              wr_ptr <= wr_ptr + 1'b1;
              len    <= (ADDR_W+1)'(1);
              state  <= RECV;
            end else begin
              state  <= DROP;
            end
          end
        end
        RECV: begin
          if (cmd_flag) begin
            if (wr_en) begin
              wr_ptr <= wr_ptr + 1'b1;
              len    <= len + 1'b1;
            end else begin
              state  <= DROP;
            end
          end else begin
            cm_ptr <= wr_ptr;
            state  <= IDLE;
          end
        end
        DROP: begin
          if (!cmd_flag) begin
            wr_ptr <= cm_ptr;
            if (frame_drop_cnt != 16'hFFFF) begin
              frame_drop_cnt <= frame_drop_cnt + 16'd1;
            end
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage array; contents are don't-care after reset since every pointer
  // returns to zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= cmd_data;
    end
  end

`ifdef DL_FIFO_SHOWAHEAD_EN

  logic out_vld;
  logic load;

  // Refill the output register whenever it is empty or being acknowledged,
  // as long as a committed word is waiting in memory.
  assign load = (mem_used != '0) && (!out_vld || dl_fifo_rdreq);

  // Output register of the fall-through read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr         <= '0;
      out_vld        <= 1'b0;
      dl_fifo_rddata <= '0;
    end else if (load) begin
      dl_fifo_rddata <= mem[rd_ptr[ADDR_W-1:0]];
      rd_ptr         <= rd_ptr + 1'b1;
      out_vld        <= 1'b1;
    end else if (dl_fifo_rdreq) begin
      out_vld        <= 1'b0;
    end
  end

  assign dl_fifo_rdusedw = mem_used + {{ADDR_W{1'b0}}, out_vld};
  assign dl_fifo_rdempty = !out_vld;

`else

  logic pop;

  // A pop against an empty FIFO is ignored entirely.
  assign pop = dl_fifo_rdreq && (mem_used != '0);

  // Registered read port: the popped word appears after the popping edge
  // and is held until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr         <= '0;
      dl_fifo_rddata <= '0;
    end else if (pop) begin
      dl_fifo_rddata <= mem[rd_ptr[ADDR_W-1:0]];
      rd_ptr         <= rd_ptr + 1'b1;
    end
  end

  assign dl_fifo_rdusedw = mem_used;
  assign dl_fifo_rdempty = (mem_used == '0);

`endif

endmodule

// File: tb/tb_dl_frame_fifo.sv
// Directed bench for dl_frame_fifo (ADDR_W=4, MAX_FRAME=8) with a scoreboard
// queue of committed words. Works in both read modes.
module tb_dl_frame_fifo;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int MAX_FRAME = 8;
`ifdef DL_FIFO_SHOWAHEAD_EN
  localparam bit SA_MODE    = 1'b1;
  localparam int FULL_AFTER = 7;
`else
  localparam bit SA_MODE    = 1'b0;
  localparam int FULL_AFTER = 6;
`endif

  logic              clk;
  logic              rst_n;
  logic              cmd_flag;
  logic [DATA_W-1:0] cmd_data;
  logic              rdreq;
  logic [DATA_W-1:0] rddata;
  logic [ADDR_W:0]   rdusedw;
  logic              rdempty;
  logic              wrfull;
  logic [15:0]       drop_cnt;

  int                passes = 0;
  int                checks = 0;
  logic [7:0]        exp_q[$];
  logic [7:0]        last_pop;

  dl_frame_fifo #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MAX_FRAME(MAX_FRAME)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_flag       (cmd_flag),
    .cmd_data       (cmd_data),
    .dl_fifo_rdreq  (rdreq),
    .dl_fifo_rddata (rddata),
    .dl_fifo_rdusedw(rdusedw),
    .dl_fifo_rdempty(rdempty),
    .dl_fifo_wrfull (wrfull),
    .frame_drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame, then the commit/rewind cycle and one idle cycle.
  task automatic send_frame(input int n, input logic [7:0] base, input bit commit);
    for (int i = 0; i < n; i++) begin
      cmd_flag = 1'b1;
      cmd_data = base + 8'(i);
      if (commit) exp_q.push_back(base + 8'(i));
      tick();
    end
    cmd_flag = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    check({tag, "_avail"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    check({tag, "_notempty"}, 32'(rdempty), 32'd0);
    e = exp_q.pop_front();
`ifdef DL_FIFO_SHOWAHEAD_EN
    check({tag, "_data"}, 32'(rddata), 32'(e));
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
`else
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    check({tag, "_data"}, 32'(rddata), 32'(e));
`endif
    last_pop = e;
  endtask

  initial begin
    rst_n    = 1'b0;
    cmd_flag = 1'b0;
    cmd_data = '0;
    rdreq    = 1'b0;
    last_pop = '0;
    #12;
    check("rst_rdempty", 32'(rdempty), 32'd1);
    check("rst_rdusedw", 32'(rdusedw), 32'd0);
    check("rst_wrfull", 32'(wrfull), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a frame with data already in the read port.
    send_frame(2, 8'h77, 1'b1);
    pop_check("pre_rst_pop");
    for (int i = 0; i < 3; i++) begin
      cmd_flag = 1'b1;
      cmd_data = 8'hE0 + 8'(i);
      tick();
    end
    rst_n = 1'b0;
    #2;
    check("mid_rst_rddata", 32'(rddata), 32'd0);
    check("mid_rst_rdusedw", 32'(rdusedw), 32'd0);
    check("mid_rst_rdempty", 32'(rdempty), 32'd1);
    check("mid_rst_wrfull", 32'(wrfull), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    cmd_flag = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(2, 8'h21, 1'b1);
    check("post_rst_used", 32'(rdusedw), 32'd2);
    pop_check("post_rst_pop0");
    pop_check("post_rst_pop1");
    check("post_rst_empty", 32'(rdempty), 32'd1);

    // Four-word frame: nothing visible until the commit edge.
    for (int i = 0; i < 4; i++) begin
      cmd_flag = 1'b1;
      cmd_data = 8'h11 + 8'(i);
      exp_q.push_back(8'h11 + 8'(i));
      tick();
      check("f4_wr_empty", 32'(rdempty), 32'd1);
      check("f4_wr_used", 32'(rdusedw), 32'd0);
    end
    cmd_flag = 1'b0;
    tick();
    check("f4_commit_used", 32'(rdusedw), 32'd4);
    check("f4_commit_empty", 32'(rdempty), 32'(SA_MODE));
    tick();
    check("f4_ready_empty", 32'(rdempty), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("f4_pop");
    check("f4_end_empty", 32'(rdempty), 32'd1);
    check("f4_end_used", 32'(rdusedw), 32'd0);
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    check("empty_rd_data", 32'(rddata), 32'(last_pop));
    check("empty_rd_empty", 32'(rdempty), 32'd1);
    check("empty_rd_used", 32'(rdusedw), 32'd0);

    // Overflow: 10 committed words, then an 8-word frame that cannot fit.
    send_frame(5, 8'h30, 1'b1);
    send_frame(5, 8'h40, 1'b1);
    check("ovf_used10", 32'(rdusedw), 32'd10);
    check("ovf_wrfull0", 32'(wrfull), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cmd_flag = 1'b1;
      cmd_data = 8'h50 + 8'(i);
      tick();
      check("ovf_wrfull", 32'(wrfull), 32'((i + 1) >= FULL_AFTER));
      check("ovf_used", 32'(rdusedw), 32'd10);
    end
    cmd_flag = 1'b0;
    tick();
    check("ovf_rewind_full", 32'(wrfull), 32'd0);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
    check("ovf_rewind_used", 32'(rdusedw), 32'd10);
    for (int i = 0; i < 10; i++) pop_check("ovf_pop");
    check("ovf_end_empty", 32'(rdempty), 32'd1);

    // Length limit: 9 words dropped, 8 words accepted.
    send_frame(9, 8'h80, 1'b0);
    check("len_drop_cnt", 32'(drop_cnt), 32'd2);
    check("len_drop_used", 32'(rdusedw), 32'd0);
    send_frame(8, 8'h90, 1'b1);
    check("len_ok_used", 32'(rdusedw), 32'd8);
    check("len_ok_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) pop_check("len_pop");
    check("len_end_empty", 32'(rdempty), 32'd1);

    // Reads of an old frame overlapping the writes of a new one.
    send_frame(4, 8'hA0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cmd_flag = 1'b1;
      cmd_data = 8'hB0 + 8'(i);
      if (i < 4) pop_check("cc_pop");
      else tick();
      check("cc_used", 32'(rdusedw), 32'((i < 4) ? (3 - i) : 0));
    end
    cmd_flag = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'hB0 + 8'(i));
    check("cc_commit_used", 32'(rdusedw), 32'd6);
    tick();
    for (int i = 0; i < 6; i++) pop_check("cc_new_pop");
    check("cc_end_empty", 32'(rdempty), 32'd1);

    // Two-word frame 0xA5, 0x5A; exercises fall-through timing when enabled.
    cmd_flag = 1'b1;
    cmd_data = 8'hA5;
    tick();
    cmd_data = 8'h5A;
    tick();
    cmd_flag = 1'b0;
    tick();
    check("a5_commit_empty", 32'(rdempty), 32'(SA_MODE));
    tick();
    check("a5_ready_empty", 32'(rdempty), 32'd0);
`ifdef DL_FIFO_SHOWAHEAD_EN
    check("a5_head", 32'(rddata), 32'hA5);
    rdreq = 1'b1;
    tick();
    check("a5_next", 32'(rddata), 32'h5A);
    check("a5_next_empty", 32'(rdempty), 32'd0);
    tick();
    rdreq = 1'b0;
    check("a5_done_empty", 32'(rdempty), 32'd1);
`else
    rdreq = 1'b1;
    tick();
    check("a5_head", 32'(rddata), 32'hA5);
    tick();
    rdreq = 1'b0;
    check("a5_next", 32'(rddata), 32'h5A);
    check("a5_done_empty", 32'(rdempty), 32'd1);
`endif
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    check("a5_empty_rd_data", 32'(rddata), 32'h5A);
    check("a5_empty_rd_used", 32'(rdusedw), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
